// File: rtl/ds_operand_stage_pkg.sv
// Shared widths and IF->ID bus layout for the decode-stage operand logic.
// IF packs with pack_fs_bus() so both stages agree on the field order.
package ds_operand_stage_pkg;

    localparam int DS_XLEN      = 32;
    localparam int INST_W       = 32;
    localparam int DS_FS_W      = INST_W + DS_XLEN;
    localparam int REG_AW       = 5;

    // Bus ordering {inst, pc}: pc in the low bits, inst directly above it.
    localparam int BUS_PC_LSB   = 0;
    localparam int BUS_INST_LSB = BUS_PC_LSB + DS_XLEN;

    function automatic logic [DS_FS_W-1:0] pack_fs_bus(input logic [INST_W-1:0]  inst,
                                                       input logic [DS_XLEN-1:0] pc);
        logic [DS_FS_W-1:0] bus;
        bus = '0;
        bus[BUS_INST_LSB +: INST_W] = inst;
        bus[BUS_PC_LSB +: DS_XLEN]  = pc;
        return bus;
    endfunction

endpackage

// File: rtl/ds_operand_stage_if.sv
// IF->ID hand-off: valid/allow_in handshake plus the packed {inst, pc} bus.
interface ds_operand_stage_if #(
    parameter int FS_W = ds_operand_stage_pkg::DS_FS_W
);
    import ds_operand_stage_pkg::*;

    logic            fs_to_ds_valid;
    logic            ds_allow_in;
    logic [FS_W-1:0] fs_to_ds_bus;

    modport master (output fs_to_ds_valid, output fs_to_ds_bus, input ds_allow_in);
    modport slave  (input fs_to_ds_valid, input fs_to_ds_bus, output ds_allow_in);

endinterface

// File: rtl/ds_fwd_select.sv
// Per-operand forwarding scan: the youngest matching producer wins, and if it
// is not ready yet the operand stalls even when an older producer is ready.
module ds_fwd_select
    import ds_operand_stage_pkg::*;
#(
    parameter int NUM_FWD = 3,
    parameter int XLEN    = DS_XLEN
) (
    input  logic [REG_AW-1:0]         addr,
    input  logic                      used,
    input  logic [NUM_FWD-1:0]        fwd_we,
    input  logic [REG_AW*NUM_FWD-1:0] fwd_dest,
    input  logic [XLEN*NUM_FWD-1:0]   fwd_wdata,
    input  logic [NUM_FWD-1:0]        fwd_ready,
    input  logic [XLEN-1:0]           rf_rdata,
    output logic [XLEN-1:0]           value,
    output logic                      stall
);

    logic [NUM_FWD-1:0] hit;
    logic               found;

    generate
        for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_hit
            assign hit[gi] = used & fwd_we[gi] & (addr != '0)
                           & (fwd_dest[gi*REG_AW +: REG_AW] == addr);
        end
    endgenerate

    always_comb begin
        value = rf_rdata;
        stall = 1'b0;
        found = 1'b0;
        for (int i = 0; i < NUM_FWD; i++) begin
            if (hit[i] && !found) begin
                found = 1'b1;
                stall = ~fwd_ready[i];
                value = fwd_ready[i] ? fwd_wdata[i*XLEN +: XLEN] : '0;
            end
        end
        // r0 reads as zero no matter what the regfile or producers say.
        if (addr == '0) begin
            value = '0;
        end
    end

endmodule

// File: rtl/ds_operand_stage.sv
// Decode stage: IF->ID pipeline register, operand hazard resolution against
// NUM_FWD producers, branch cancel on departure, and a saturating stall counter.
module ds_operand_stage
    import ds_operand_stage_pkg::*;
#(
    parameter int XLEN        = DS_XLEN,
    parameter int FS_W        = DS_FS_W,
    parameter int NUM_FWD     = 3,
    parameter int STALL_CNT_W = 32
) (
    input  logic                      clk,
    input  logic                      resetn,
    ds_operand_stage_if.slave         fs_if,
    output logic [INST_W-1:0]         ds_inst,
    output logic [XLEN-1:0]           ds_pc,
    output logic                      ds_valid,
    input  logic [REG_AW-1:0]         rs1_addr,
    input  logic [REG_AW-1:0]         rs2_addr,
    input  logic                      rs1_used,
    input  logic                      rs2_used,
    input  logic [XLEN-1:0]           rf_rdata1,
    input  logic [XLEN-1:0]           rf_rdata2,
    input  logic [NUM_FWD-1:0]        fwd_we,
    input  logic [REG_AW*NUM_FWD-1:0] fwd_dest,
    input  logic [XLEN*NUM_FWD-1:0]   fwd_wdata,
    input  logic [NUM_FWD-1:0]        fwd_ready,
    output logic [XLEN-1:0]           rs1_value,
    output logic [XLEN-1:0]           rs2_value,
    input  logic                      br_taken_in,
    output logic                      br_cancel,
    input  logic                      es_allow_in,
    output logic                      ds_to_es_valid,
    input  logic                      flush,
    output logic [STALL_CNT_W-1:0]    stall_cnt
);

    localparam int INST_LSB = BUS_PC_LSB + XLEN;

    logic [FS_W-1:0]        fs_bus_reg;
    logic                   ds_valid_reg;
    logic                   ds_valid_next;
    logic [STALL_CNT_W-1:0] stall_cnt_reg;
    logic                   stall_1;
    logic                   stall_2;
    logic                   stall;
    logic                   ds_ready_go;
    logic                   allow_in;

    ds_fwd_select #(.NUM_FWD(NUM_FWD), .XLEN(XLEN)) u_fwd_rs1 (
        .addr      (rs1_addr),
        .used      (rs1_used),
        .fwd_we    (fwd_we),
        .fwd_dest  (fwd_dest),
        .fwd_wdata (fwd_wdata),
        .fwd_ready (fwd_ready),
        .rf_rdata  (rf_rdata1),
        .value     (rs1_value),
        .stall     (stall_1)
    );

    ds_fwd_select #(.NUM_FWD(NUM_FWD), .XLEN(XLEN)) u_fwd_rs2 (
        .addr      (rs2_addr),
        .used      (rs2_used),
        .fwd_we    (fwd_we),
        .fwd_dest  (fwd_dest),
        .fwd_wdata (fwd_wdata),
        .fwd_ready (fwd_ready),
        .rf_rdata  (rf_rdata2),
        .value     (rs2_value),
        .stall     (stall_2)
    );

    assign stall          = ds_valid_reg & (stall_1 | stall_2);
    assign ds_ready_go    = ~stall;
    assign allow_in       = ~ds_valid_reg | (ds_ready_go & es_allow_in);
    assign ds_to_es_valid = ds_valid_reg & ds_ready_go & ~flush;
    // Cancel only on the cycle the branch actually leaves ID.
    assign br_cancel      = ds_valid_reg & br_taken_in & ds_ready_go & es_allow_in & ~flush;

    assign fs_if.ds_allow_in = allow_in;
    assign ds_valid          = ds_valid_reg;
    assign ds_inst           = fs_bus_reg[INST_LSB +: INST_W];
    assign ds_pc             = fs_bus_reg[BUS_PC_LSB +: XLEN];
    assign stall_cnt         = stall_cnt_reg;

    always_comb begin
        ds_valid_next = ds_valid_reg;
        if (flush) begin
            ds_valid_next = 1'b0;
        end else if (br_cancel) begin
            ds_valid_next = 1'b0;
        end else if (allow_in) begin
            ds_valid_next = fs_if.fs_to_ds_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fs_bus_reg    <= '0;
            ds_valid_reg  <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            // Loads even under flush/cancel; ds_valid decides whether it lives.
            if (fs_if.fs_to_ds_valid && allow_in) begin
                fs_bus_reg <= fs_if.fs_to_ds_bus;
            end
            ds_valid_reg <= ds_valid_next;
            if (stall && !(&stall_cnt_reg)) begin
                stall_cnt_reg <= stall_cnt_reg + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_ds_operand_stage.sv
// Bench for ds_operand_stage: operand-resolution vector table through a
// scoreboard queue, then hand-written stall/branch/flush/saturation sequences.
module tb_ds_operand_stage;
    import ds_operand_stage_pkg::*;

    localparam int XLEN    = 32;
    localparam int NUM_FWD = 3;
    localparam int CNT_W   = 4;

    logic              clk;
    logic              resetn;
    logic [31:0]       ds_inst;
    logic [XLEN-1:0]   ds_pc;
    logic              ds_valid;
    logic [4:0]        rs1_addr, rs2_addr;
    logic              rs1_used, rs2_used;
    logic [XLEN-1:0]   rf_rdata1, rf_rdata2;
    logic [NUM_FWD-1:0] fwd_we, fwd_ready;
    logic [5*NUM_FWD-1:0] fwd_dest;
    logic [XLEN*NUM_FWD-1:0] fwd_wdata;
    logic [XLEN-1:0]   rs1_value, rs2_value;
    logic              br_taken_in, br_cancel;
    logic              es_allow_in, ds_to_es_valid;
    logic              flush;
    logic [CNT_W-1:0]  stall_cnt;

    int checks = 0;
    int errors = 0;

    ds_operand_stage_if #(.FS_W(DS_FS_W)) fs_if ();

    ds_operand_stage #(
        .XLEN(XLEN), .FS_W(DS_FS_W), .NUM_FWD(NUM_FWD), .STALL_CNT_W(CNT_W)
    ) dut (
        .clk(clk), .resetn(resetn), .fs_if(fs_if),
        .ds_inst(ds_inst), .ds_pc(ds_pc), .ds_valid(ds_valid),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_used(rs1_used), .rs2_used(rs2_used),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_we(fwd_we), .fwd_dest(fwd_dest), .fwd_wdata(fwd_wdata), .fwd_ready(fwd_ready),
        .rs1_value(rs1_value), .rs2_value(rs2_value),
        .br_taken_in(br_taken_in), .br_cancel(br_cancel),
        .es_allow_in(es_allow_in), .ds_to_es_valid(ds_to_es_valid),
        .flush(flush), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [4:0]  a1; logic u1; logic [4:0] a2; logic u2;
        logic [2:0]  we; logic [2:0] rdy;
        logic [4:0]  d0, d1, d2;
        logic [31:0] w0, w1, w2;
        logic [31:0] rf1, rf2;
        logic [31:0] e1, e2; logic chk2; logic go;
    } vec_t;

    typedef struct {
        int idx; logic [31:0] e1, e2; logic chk2; logic go;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_fwd();
        fwd_we = '0; fwd_ready = '0; fwd_dest = '0; fwd_wdata = '0;
        rs1_addr = 5'd0; rs2_addr = 5'd0; rs1_used = 1'b0; rs2_used = 1'b0;
    endtask

    task automatic drive_vec(input vec_t v);
        rs1_addr = v.a1; rs1_used = v.u1; rs2_addr = v.a2; rs2_used = v.u2;
        fwd_we = v.we; fwd_ready = v.rdy;
        fwd_dest = {v.d2, v.d1, v.d0};
        fwd_wdata = {v.w2, v.w1, v.w0};
        rf_rdata1 = v.rf1; rf_rdata2 = v.rf2;
    endtask

    initial begin
        exp_t e;
        resetn = 1'b0; fs_if.fs_to_ds_valid = 1'b0; fs_if.fs_to_ds_bus = '0;
        rf_rdata1 = '0; rf_rdata2 = '0; br_taken_in = 1'b0; es_allow_in = 1'b1; flush = 1'b0;
        clear_fwd();

        //                a1  u1  a2  u2  we    rdy   d0  d1  d2  w0     w1     w2     rf1    rf2    e1     e2    chk2 go
        vecs[0] = '{5'd5, 1, 5'd3, 1, 3'b101, 3'b101, 5, 0, 5, 32'h11, 32'h0, 32'h22, 32'h55, 32'h33, 32'h11, 32'h33, 1, 1};
        vecs[1] = '{5'd0, 1, 5'd0, 0, 3'b001, 3'b001, 0, 0, 0, 32'hFFFF, 32'h0, 32'h0, 32'hDEAD, 32'hBEEF, 32'h0, 32'h0, 1, 1};
        vecs[2] = '{5'd4, 1, 5'd9, 1, 3'b011, 3'b010, 9, 9, 0, 32'h90, 32'h99, 32'h0, 32'h44, 32'h0, 32'h44, 32'h0, 0, 0};
        vecs[3] = '{5'd6, 1, 5'd8, 1, 3'b010, 3'b011, 6, 6, 0, 32'hAA, 32'h66, 32'h0, 32'h60, 32'h88, 32'h66, 32'h88, 1, 1};
        vecs[4] = '{5'd7, 0, 5'd2, 1, 3'b001, 3'b000, 7, 0, 0, 32'h70, 32'h0, 32'h0, 32'h77, 32'h22, 32'h77, 32'h22, 1, 1};
        vecs[5] = '{5'd10, 1, 5'd11, 1, 3'b000, 3'b111, 10, 11, 10, 32'h1, 32'h2, 32'h3, 32'hA0, 32'hB0, 32'hA0, 32'hB0, 1, 1};
        vecs[6] = '{5'd12, 1, 5'd13, 1, 3'b110, 3'b010, 0, 13, 12, 32'h0, 32'h1313, 32'h1212, 32'h0, 32'h0, 32'h0, 32'h1313, 1, 0};
        vecs[7] = '{5'd14, 1, 5'd15, 1, 3'b011, 3'b011, 15, 14, 0, 32'hF0, 32'hE0, 32'h0, 32'h1, 32'h2, 32'hE0, 32'hF0, 1, 1};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ds_valid", ds_valid, 0);
        check("rst_ds_inst", ds_inst, 0);
        check("rst_ds_pc", ds_pc, 0);
        check("rst_allow_in", fs_if.ds_allow_in, 1);
        check("rst_to_es_valid", ds_to_es_valid, 0);
        check("rst_br_cancel", br_cancel, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        $display("reset: state checked");

        // Park one instruction in ID (EX back-pressured) for the operand table
        @(posedge clk); #1;
        resetn = 1'b1; es_allow_in = 1'b0;
        fs_if.fs_to_ds_valid = 1'b1; fs_if.fs_to_ds_bus = pack_fs_bus(32'h00000013, 32'h0000_0100);
        @(posedge clk); #1;
        fs_if.fs_to_ds_valid = 1'b0;

        for (int i = 0; i < 8; i++) begin
            drive_vec(vecs[i]);
            sb.push_back('{i, vecs[i].e1, vecs[i].e2, vecs[i].chk2, vecs[i].go});
            @(negedge clk);
            e = sb.pop_front();
            check($sformatf("vec%0d_rs1", e.idx), rs1_value, e.e1);
            if (e.chk2) check($sformatf("vec%0d_rs2", e.idx), rs2_value, e.e2);
            check($sformatf("vec%0d_go", e.idx), ds_to_es_valid, e.go);
            $display("vec %0d: rs1=0x%0h rs2=0x%0h to_es=%0d", e.idx, rs1_value, rs2_value, ds_to_es_valid);
            @(posedge clk); #1;
        end
        check("vec_ds_valid_held", ds_valid, 1);

        // Load-use stall on rs2
        resetn = 1'b0; clear_fwd();
        @(posedge clk); #1;
        resetn = 1'b1; es_allow_in = 1'b1;
        fs_if.fs_to_ds_valid = 1'b1; fs_if.fs_to_ds_bus = pack_fs_bus(32'h00700113, 32'h0000_1000);
        rs2_addr = 5'd7; rs2_used = 1'b1;
        fwd_we = 3'b001; fwd_ready = 3'b000; fwd_dest = {5'd0, 5'd0, 5'd7}; fwd_wdata = '0;
        @(posedge clk); #1;
        fs_if.fs_to_ds_valid = 1'b0;
        @(negedge clk);
        check("lu_ds_valid", ds_valid, 1);
        check("lu_ds_inst", ds_inst, 32'h00700113);
        check("lu_ds_pc", ds_pc, 32'h1000);
        check("lu_allow_in", fs_if.ds_allow_in, 0);
        check("lu_to_es_valid", ds_to_es_valid, 0);
        check("lu_cnt0", stall_cnt, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("lu_cnt3", stall_cnt, 3);
        check("lu_still_stalled", ds_to_es_valid, 0);
        fwd_ready = 3'b001; fwd_wdata = {32'h0, 32'h0, 32'h0000ABCD};
        #1;
        check("lu_rs2_value", rs2_value, 32'hABCD);
        check("lu_release_to_es", ds_to_es_valid, 1);
        check("lu_release_allow", fs_if.ds_allow_in, 1);
        @(posedge clk); #1;
        clear_fwd();
        @(negedge clk);
        check("lu_after_valid", ds_valid, 0);
        check("lu_after_cnt", stall_cnt, 3);
        $display("load-use: stall_cnt=%0d", stall_cnt);

        // Taken branch under EX back-pressure
        @(posedge clk); #1;
        fs_if.fs_to_ds_valid = 1'b1; fs_if.fs_to_ds_bus = pack_fs_bus(32'h00000063, 32'h0000_3000);
        es_allow_in = 1'b0; br_taken_in = 1'b1;
        @(posedge clk); #1;
        fs_if.fs_to_ds_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("bp%0d_br_cancel", k), br_cancel, 0);
            check($sformatf("bp%0d_ds_valid", k), ds_valid, 1);
            @(posedge clk);
        end
        #1;
        es_allow_in = 1'b1;
        fs_if.fs_to_ds_valid = 1'b1; fs_if.fs_to_ds_bus = pack_fs_bus(32'h00000013, 32'h0000_3004);
        @(negedge clk);
        check("bp_br_cancel_go", br_cancel, 1);
        check("bp_to_es_valid", ds_to_es_valid, 1);
        @(posedge clk); #1;
        fs_if.fs_to_ds_valid = 1'b0;
        @(negedge clk);
        check("bp_after_valid", ds_valid, 0);
        check("bp_after_cancel", br_cancel, 0);
        $display("branch backpressure: cancel on departure only");

        // Flush against a taken branch in ID
        @(posedge clk); #1;
        fs_if.fs_to_ds_valid = 1'b1; fs_if.fs_to_ds_bus = pack_fs_bus(32'h00000063, 32'h0000_4000);
        @(posedge clk); #1;
        fs_if.fs_to_ds_bus = pack_fs_bus(32'h00000013, 32'h0000_4008);
        flush = 1'b1;
        @(negedge clk);
        check("fl_ds_valid", ds_valid, 1);
        check("fl_br_cancel", br_cancel, 0);
        check("fl_to_es_valid", ds_to_es_valid, 0);
        @(posedge clk); #1;
        flush = 1'b0; fs_if.fs_to_ds_valid = 1'b0; br_taken_in = 1'b0;
        @(negedge clk);
        check("fl_after_valid", ds_valid, 0);
        check("fl_dead_load_pc", ds_pc, 32'h4008);
        $display("flush: branch suppressed, dead load");

        // Stall-counter saturation, then reset mid-stall
        @(posedge clk); #1;
        fs_if.fs_to_ds_valid = 1'b1; fs_if.fs_to_ds_bus = pack_fs_bus(32'h00000033, 32'h0000_5000);
        rs1_addr = 5'd9; rs1_used = 1'b1;
        fwd_we = 3'b100; fwd_ready = 3'b000; fwd_dest = {5'd9, 5'd0, 5'd0};
        @(posedge clk); #1;
        fs_if.fs_to_ds_valid = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("sat_cnt", stall_cnt, 15);
        check("sat_allow_in", fs_if.ds_allow_in, 0);
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rs_mid_cnt", stall_cnt, 0);
        check("rs_mid_valid", ds_valid, 0);
        check("rs_mid_allow", fs_if.ds_allow_in, 1);
        resetn = 1'b1; clear_fwd();
        fs_if.fs_to_ds_valid = 1'b1; fs_if.fs_to_ds_bus = pack_fs_bus(32'h00000013, 32'h0000_6000);
        @(posedge clk); #1;
        fs_if.fs_to_ds_valid = 1'b0;
        @(negedge clk);
        check("rs_next_valid", ds_valid, 1);
        check("rs_next_pc", ds_pc, 32'h6000);
        check("rs_next_cnt", stall_cnt, 0);
        $display("saturation/reset: cnt=%0d", stall_cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ds_operand_stage.md
Name: ds_operand_stage

Overview:
- Parametrised successor of the decode-stage operand and hazard logic.
- Owns the IF→ID pipeline register and the valid/allow_in handshake.
- Resolves operand hazards against NUM_FWD producer stages. Each producer can flag its data as not yet ready (load, multi-cycle op), which stalls decode.
- Adds an external flush, a branch cancel that fires only when the branch actually leaves ID, and a saturating stall-cycle counter.
- Sits between the IF stage and EX; the instruction decoder and regfile attach combinationally.

Parameters:
- XLEN, 32: datapath width.
- FS_W, 64: width of the fs_to_ds bus, ordered {inst, pc}.
- NUM_FWD, 3: number of forwarding sources. Index 0 is the youngest (EX), higher indices are older.
- STALL_CNT_W, 32: width of the stall counter.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- fs_to_ds_valid  in  1  IF has a valid instruction.
- ds_allow_in  out  1  ID can accept an instruction this cycle.
- fs_to_ds_bus  in  FS_W  {inst[31:0], pc[XLEN-1:0]}.
- ds_inst  out  32  registered instruction, fed to the decoder.
- ds_pc  out  XLEN  registered PC.
- ds_valid  out  1  ID holds a live instruction.
- rs1_addr, rs2_addr  in  5 each  source register addresses from the decoder.
- rs1_used, rs2_used  in  1 each  the decoded instruction reads that source.
- rf_rdata1, rf_rdata2  in  XLEN each  regfile read data.
- fwd_we  in  NUM_FWD  producer i writes a register.
- fwd_dest  in  5*NUM_FWD  destination of producer i, in slice [5i+4:5i].
- fwd_wdata  in  XLEN*NUM_FWD  result of producer i.
- fwd_ready  in  NUM_FWD  fwd_wdata[i] is final this cycle.
- rs1_value, rs2_value  out  XLEN each  resolved operand values.
- br_taken_in  in  1  decoder/comparator says the branch in ID is taken.
- br_cancel  out  1  kill the younger fetch and redirect the PC.
- es_allow_in  in  1  EX can accept.
- ds_to_es_valid  out  1  hand-off valid to EX.
- flush  in  1  exception/ertn flush from WB.
- stall_cnt  out  STALL_CNT_W  count of stalled cycles.

Behaviour:
- Reset (resetn=0 at a clk edge):
  - ds_valid=0, pipeline register=0, stall_cnt=0.
  - All outputs derived from these are therefore 0: ds_inst, ds_pc, ds_to_es_valid, br_cancel.
  - ds_allow_in=1.
- Pipeline register loads fs_to_ds_bus when fs_to_ds_valid & ds_allow_in. Otherwise it holds its value.
- ds_valid next-state, in priority order:
  1. flush → 0.
  2. br_cancel → 0; the instruction arriving from IF is discarded.
  3. ds_allow_in → fs_to_ds_valid.
  4. Otherwise hold.
- Operand resolution, per operand k with address a = rsk_addr:
  - Scan producers i = 0..NUM_FWD-1 and take the first hit.
  - A hit is rsk_used & fwd_we[i] & fwd_dest[i]==a & a!=0.
  - Hit with fwd_ready[i]=1 → value = fwd_wdata[i].
  - Hit with fwd_ready[i]=0 → value = don't-care, and stall_k=1.
  - No hit → value = rf_rdata_k.
  - a==0 → value forced to 0.
  - An older ready match never overrides a younger not-ready match.
- Handshake (all combinational, zero latency):
  - stall = ds_valid & (stall_1 | stall_2).
  - ds_ready_go = ~stall.
  - ds_allow_in = ~ds_valid | (ds_ready_go & es_allow_in).
  - ds_to_es_valid = ds_valid & ds_ready_go & ~flush.
- br_cancel = ds_valid & br_taken_in & ds_ready_go & es_allow_in & ~flush.
  - Asserts exactly once per taken branch, in its departure cycle.
  - Never asserts while the branch is stalled or back-pressured.
- stall_cnt increments on every cycle where stall=1. It saturates at all-ones and never wraps.
- Simultaneous flush and fs_to_ds_valid: the register still loads, but ds_valid=0, so the loaded instruction is dead.
- Reset mid-stall: everything clears in that cycle. The next cycle accepts a new instruction.

Decomposition:
- Shared package holds:
  - widths XLEN, FS_W, REG_AW=5;
  - the bus-ordering constants, so IF and ID agree on the field layout.
- One sub-module is natural: ds_fwd_select. It is the per-operand priority scan, parametrised on NUM_FWD and XLEN, and is instantiated twice.

Test Plan:
- Producer-priority forwarding: rs1_addr=5; producer 0 writes r5=0x11 ready; producer 2 writes r5=0x22 ready → rs1_value=0x11, no stall.
- Load-use stall: producer 0 has dest 7, ready=0; rs2_addr=7 used, ds_valid=1 → ds_allow_in=0, ds_to_es_valid=0, stall_cnt+1 per cycle. Ready rises with data 0xABCD → rs2_value=0xABCD and the hand-off occurs that cycle.
- r0 case: rs1_addr=0, producer 0 writes dest 0 with 0xFFFF → rs1_value=0, no stall.
- Branch under back-pressure: taken branch with es_allow_in=0 for 3 cycles → br_cancel stays 0 for those cycles. On the first cycle es_allow_in=1 → br_cancel=1 for one cycle, and ds_valid=0 the following cycle.
- Flush vs branch: flush=1 with a taken branch in ID → br_cancel=0, ds_to_es_valid=0, ds_valid=0 next cycle.
- Counter saturation: with STALL_CNT_W=4, hold a stall for 20 cycles → stall_cnt=15. resetn=0 for one edge → stall_cnt=0 and ds_valid=0.
